// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined): 2-FF synchroniser, mid-bit sampling, LSB first.
// Latency: rx_done rises 2 sync clks + HALF_BIT + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) after the start edge.
// Backpressure: none; each byte is presented for one rx_done cycle and held in data_out until the next frame.
module uart_rx #(
   parameter int CLK_FREQ  = 12_000_000,
   parameter int BAUD_RATE = 9_600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       rx_done,
   output logic       frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;
`ifdef UART_RX_PARITY_EN
   logic          par_q, par_d;
   logic          perr_q, perr_d;
`endif

   // Next-state logic: synchroniser shift, baud counting, bit capture and frame delivery
   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      done_d    = 1'b0;
      ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = perr_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            // A line that is high again at mid-start-bit was only a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = rx_s_q;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at mid-stop-bit so a start bit with no idle gap is still caught.
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               data_d  = shift_q;
               ferr_d  = ~rx_s_q;
               done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
               perr_d  = (^shift_q) != par_q;
`endif
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; synchroniser resets to the idle-high line level
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign data_out  = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule
